ili9488_spi_tx: RTL and testbench

ILI9488_SPI_TX -- requirements
Module: ili9488_spi_tx

---
 rtl/ili9488_spi_tx.sv | 167 ++++++++++++++++
 tb/tb_ili9488_spi_tx.sv | 274 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/ili9488_spi_tx.sv
// Write-only serial transmitter for the ILI9488 panel. Each sck_src rising edge is one tick,
// and two ticks make one SPI mode-0 bit. Define ILI9488_3WIRE_EN for 9-bit frames with the DC bit inline.
module ili9488_spi_tx #(
  parameter int CS_GAP = 2
) (
  input  logic       clk_in,
  input  logic       rst,
  input  logic       sck_src,
  input  logic       tx_valid,
  output logic       tx_ready,
  input  logic [7:0] tx_data,
  input  logic       tx_dc,
  input  logic       tx_last,
  output logic       lcd_cs_n,
  output logic       lcd_scl,
  output logic       lcd_sdi,
  output logic       lcd_dc,
  output logic       busy
);

`ifdef ILI9488_3WIRE_EN
  localparam int FRAME_BITS = 9;
`else
  localparam int FRAME_BITS = 8;
`endif
  localparam logic [4:0] LAST_TICK = 5'(2 * FRAME_BITS - 1);
  localparam logic [7:0] GAP_LAST  = 8'(CS_GAP - 1);

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    GAP
  } state_t;

  state_t                  state_q, state_d;
  logic                    sckPrev_q;
  logic [4:0]              tickCnt_q, tickCnt_d;
  logic [7:0]              gapCnt_q, gapCnt_d;
  logic [FRAME_BITS-1:0]   shift_q, shift_d;
  logic                    last_q, last_d;
  logic                    csN_q, csN_d;
  logic                    scl_q, scl_d;
  logic                    sdi_q, sdi_d;
  logic                    dc_q, dc_d;
  logic                    ready_q, ready_d;
  logic                    busy_q, busy_d;

  logic                    tick;
  logic                    accept;
  logic [FRAME_BITS-1:0]   frame;
  logic                    frameDc;

  assign tick   = sck_src & ~sckPrev_q;
  assign accept = (state_q == IDLE) & ready_q & tx_valid;

  // In 3-wire mode the DC flag travels as the leading bit and the DC pin stays low.
`ifdef ILI9488_3WIRE_EN
  assign frame   = {tx_dc, tx_data};
  assign frameDc = 1'b0;
`else
  assign frame   = tx_data;
  assign frameDc = tx_dc;
`endif

  always_comb begin
    state_d   = state_q;
    tickCnt_d = tickCnt_q;
    gapCnt_d  = gapCnt_q;
    shift_d   = shift_q;
    last_d    = last_q;
    csN_d     = csN_q;
    scl_d     = scl_q;
    sdi_d     = sdi_q;
    dc_d      = dc_q;

    unique case (state_q)
      IDLE: begin
        if (accept) begin
          shift_d   = {frame[FRAME_BITS-2:0], 1'b0};
          sdi_d     = frame[FRAME_BITS-1];
          dc_d      = frameDc;
          last_d    = tx_last;
          csN_d     = 1'b0;
          scl_d     = 1'b0;
          tickCnt_d = 5'd0;
          state_d   = SHIFT;
        end
      end
      SHIFT: begin
        if (tick) begin
          tickCnt_d = tickCnt_q + 5'd1;
          if (!scl_q) begin
            scl_d = 1'b1;
          end else begin
            // Falling SCL edge: the next bit goes out while SCL is low.
            scl_d   = 1'b0;
            sdi_d   = shift_q[FRAME_BITS-1];
            shift_d = {shift_q[FRAME_BITS-2:0], 1'b0};
            if (tickCnt_q == LAST_TICK) begin
              tickCnt_d = 5'd0;
              if (last_q) begin
                csN_d    = 1'b1;
                gapCnt_d = 8'd0;
                state_d  = GAP;
              end else begin
                state_d  = IDLE;
              end
            end
          end
        end
      end
      GAP: begin
        if (tick) begin
          if (gapCnt_q == GAP_LAST) begin
            gapCnt_d = 8'd0;
            state_d  = IDLE;
          end else begin
            gapCnt_d = gapCnt_q + 8'd1;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    // Ready only after a full idle cycle, so it trails every return to IDLE by one clock.
    ready_d = (state_q == IDLE) && (state_d == IDLE);
    busy_d  = (state_d != IDLE);
  end

  always_ff @(posedge clk_in) begin
    if (rst) begin
      state_q   <= IDLE;
      sckPrev_q <= 1'b1;
      tickCnt_q <= 5'd0;
      gapCnt_q  <= 8'd0;
      shift_q   <= '0;
      last_q    <= 1'b0;
      csN_q     <= 1'b1;
      scl_q     <= 1'b0;
      sdi_q     <= 1'b0;
      dc_q      <= 1'b0;
      ready_q   <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      sckPrev_q <= sck_src;
      tickCnt_q <= tickCnt_d;
      gapCnt_q  <= gapCnt_d;
      shift_q   <= shift_d;
      last_q    <= last_d;
      csN_q     <= csN_d;
      scl_q     <= scl_d;
      sdi_q     <= sdi_d;
      dc_q      <= dc_d;
      ready_q   <= ready_d;
      busy_q    <= busy_d;
    end
  end

  assign tx_ready = ready_q;
  assign busy     = busy_q;
  assign lcd_cs_n = csN_q;
  assign lcd_scl  = scl_q;
  assign lcd_sdi  = sdi_q;
  assign lcd_dc   = dc_q;

endmodule

// File: tb/tb_ili9488_spi_tx.sv
// Bench for ili9488_spi_tx: directed and random bytes compared against a bit-list model of the panel bus.
// Define ILI9488_3WIRE_EN for both files to exercise the 9-bit frame build.
module tb_ili9488_spi_tx;

  localparam int CS_GAP = 2;
  localparam int BOUND  = 5000;

  logic       clk_in = 1'b0;
  logic       rst = 1'b1;
  logic       sck_src = 1'b1;
  logic       tx_valid = 1'b0;
  logic       tx_ready;
  logic [7:0] tx_data = 8'h00;
  logic       tx_dc = 1'b0;
  logic       tx_last = 1'b0;
  logic       lcd_cs_n, lcd_scl, lcd_sdi, lcd_dc, busy;

  int checks = 0;
  int errors = 0;

  logic sckRun = 1'b0;
  logic sckHoldVal = 1'b1;
  int   halfPeriod = 5;
  int   phase = 0;

  logic obsBits[$];
  logic obsDc[$];
  int   csRises = 0;
  int   gapRecords = 0;
  int   lastGap = 0;
  int   violations = 0;

  logic expBits[$];
  logic expDc[$];
  int   obsBase = 0;
  int   expCsRises = 0;
  int   expGapRecords = 0;
  int   lastCount = 0;

  ili9488_spi_tx #(.CS_GAP(CS_GAP)) dut (
    .clk_in   (clk_in),
    .rst      (rst),
    .sck_src  (sck_src),
    .tx_valid (tx_valid),
    .tx_ready (tx_ready),
    .tx_data  (tx_data),
    .tx_dc    (tx_dc),
    .tx_last  (tx_last),
    .lcd_cs_n (lcd_cs_n),
    .lcd_scl  (lcd_scl),
    .lcd_sdi  (lcd_sdi),
    .lcd_dc   (lcd_dc),
    .busy     (busy)
  );

  always #5 clk_in = ~clk_in;

  // Tick source: free-running square wave with a programmable half period, or frozen at a level.
  always begin
    @(negedge clk_in);
    if (!sckRun) begin
      sck_src = sckHoldVal;
      phase   = 0;
    end else if (phase >= halfPeriod - 1) begin
      sck_src = ~sck_src;
      phase   = 0;
    end else begin
      phase++;
    end
  end

  // Bus monitor: records the bit and DC seen at every SCL rise and flags protocol breaches.
  always begin : monitor
    logic prevSck, prevScl, prevSdi, prevDc, prevCs, prevReady, tick, measuring;
    int   gapTicks;
    prevSck = 1'b1; prevScl = 1'b0; prevSdi = 1'b0; prevDc = 1'b0;
    prevCs = 1'b1; prevReady = 1'b0; measuring = 1'b0; gapTicks = 0;
    forever begin
      @(posedge clk_in);
      #2;
      tick = sck_src && !prevSck;
      if (rst) begin
        measuring = 1'b0;
      end else begin
        if (lcd_scl !== prevScl && !tick) violations++;
        if ((lcd_sdi !== prevSdi || lcd_dc !== prevDc) && lcd_scl) violations++;
        if (lcd_scl && !prevScl) begin
          obsBits.push_back(lcd_sdi);
          obsDc.push_back(lcd_dc);
          if (lcd_cs_n !== 1'b0) violations++;
        end
        if (lcd_cs_n && !prevCs) begin
          csRises++;
          measuring = 1'b1;
          gapTicks  = 0;
        end else if (measuring && tick) begin
          gapTicks++;
        end
        if (tx_ready && !prevReady && measuring) begin
          lastGap = gapTicks;
          gapRecords++;
          measuring = 1'b0;
        end
      end
      prevSck = sck_src; prevScl = lcd_scl; prevSdi = lcd_sdi; prevDc = lcd_dc;
      prevCs = lcd_cs_n; prevReady = tx_ready;
    end
  end

  task automatic checkEq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
      else begin
        errors++;
        $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
  endtask

  // Offer one byte, wait for the handshake, and append its frame to the expected bit list.
  task automatic applyStimulus(input logic [7:0] d, input logic dc, input logic last);
    int n = 0;
    tx_data  = d;
    tx_dc    = dc;
    tx_last  = last;
    tx_valid = 1'b1;
    while (tx_ready !== 1'b1 && n < BOUND) begin
      @(negedge clk_in);
      n++;
    end
    checkEq("accept_timeout", 32'(n < BOUND), 32'd1);
    @(negedge clk_in);
    tx_valid = 1'b0;
`ifdef ILI9488_3WIRE_EN
    expBits.push_back(dc);
    expDc.push_back(1'b0);
`endif
    for (int i = 7; i >= 0; i--) begin
      expBits.push_back(d[i]);
`ifdef ILI9488_3WIRE_EN
      expDc.push_back(1'b0);
`else
      expDc.push_back(dc);
`endif
    end
    if (last) lastCount++;
  endtask

  task automatic waitIdle(input string tag);
    int n = 0;
    while (!(tx_ready === 1'b1 && busy === 1'b0) && n < BOUND) begin
      @(negedge clk_in);
      n++;
    end
    checkEq({tag, "_idle_timeout"}, 32'(n < BOUND), 32'd1);
  endtask

  task automatic checkOutput(input string tag);
    int nObs;
    nObs = obsBits.size() - obsBase;
    checkEq({tag, "_scl_rises"}, 32'(nObs), 32'(expBits.size()));
    for (int i = 0; i < expBits.size(); i++) begin
      if (i < nObs) begin
        checkEq($sformatf("%s_bit%0d", tag, i), 32'(obsBits[obsBase + i]), 32'(expBits[i]));
        checkEq($sformatf("%s_dc%0d", tag, i), 32'(obsDc[obsBase + i]), 32'(expDc[i]));
      end
    end
    expCsRises    += lastCount;
    expGapRecords += lastCount;
    checkEq({tag, "_cs_rises"}, 32'(csRises), 32'(expCsRises));
    checkEq({tag, "_gap_records"}, 32'(gapRecords), 32'(expGapRecords));
    if (lastCount > 0) checkEq({tag, "_gap_ticks"}, 32'(lastGap), 32'(CS_GAP));
    checkEq({tag, "_violations"}, 32'(violations), 32'd0);
    obsBase   = obsBits.size();
    lastCount = 0;
    expBits.delete();
    expDc.delete();
  endtask

  initial begin
    logic [7:0] d;
    logic       dc, last;
    int         n;

    $display("[TB] reset with sck_src held high");
    rst = 1'b1;
    repeat (3) @(negedge clk_in);
    checkEq("rst_cs_n", 32'(lcd_cs_n), 32'd1);
    checkEq("rst_scl", 32'(lcd_scl), 32'd0);
    checkEq("rst_sdi", 32'(lcd_sdi), 32'd0);
    checkEq("rst_dc", 32'(lcd_dc), 32'd0);
    checkEq("rst_ready", 32'(tx_ready), 32'd0);
    checkEq("rst_busy", 32'(busy), 32'd0);
    rst = 1'b0;
    @(negedge clk_in);
    checkEq("post_rst_ready", 32'(tx_ready), 32'd1);
    repeat (4) @(negedge clk_in);
    checkEq("no_spurious_scl", 32'(obsBits.size()), 32'd0);
    checkEq("no_spurious_violations", 32'(violations), 32'd0);
    sckRun = 1'b1;

    $display("[TB] single command byte 0x2A");
    applyStimulus(8'h2A, 1'b0, 1'b1);
    waitIdle("cmd2a");
    checkOutput("cmd2a");

    $display("[TB] back-to-back 0x2C then 0xFF");
    applyStimulus(8'h2C, 1'b0, 1'b0);
    applyStimulus(8'hFF, 1'b1, 1'b1);
    waitIdle("b2b");
    checkOutput("b2b");

    $display("[TB] reset in the middle of 0x81");
    applyStimulus(8'h81, 1'b1, 1'b1);
    n = 0;
    while ((obsBits.size() - obsBase) < 5 && n < BOUND) begin
      @(negedge clk_in);
      n++;
    end
    checkEq("abort_wait_timeout", 32'(n < BOUND), 32'd1);
    rst = 1'b1;
    @(negedge clk_in);
    rst = 1'b0;
    checkEq("abort_cs_n", 32'(lcd_cs_n), 32'd1);
    checkEq("abort_scl", 32'(lcd_scl), 32'd0);
    checkEq("abort_sdi", 32'(lcd_sdi), 32'd0);
    checkEq("abort_dc", 32'(lcd_dc), 32'd0);
    checkEq("abort_busy", 32'(busy), 32'd0);
    @(negedge clk_in);
    checkEq("abort_ready", 32'(tx_ready), 32'd1);
    repeat (30) @(negedge clk_in);
    checkEq("abort_scl_rises", 32'(obsBits.size() - obsBase), 32'd5);
    for (int i = 0; i < 5; i++)
      checkEq($sformatf("abort_bit%0d", i), 32'(obsBits[obsBase + i]), 32'(expBits[i]));
    obsBase   = obsBits.size();
    lastCount = 0;
    expBits.delete();
    expDc.delete();
    applyStimulus(8'h81, 1'b1, 1'b1);
    waitIdle("after_abort");
    checkOutput("after_abort");

    $display("[TB] byte accepted while ticks are frozen");
    sckRun     = 1'b0;
    sckHoldVal = 1'b0;
    repeat (3) @(negedge clk_in);
    d  = 8'($urandom);
    dc = 1'($urandom_range(0, 1));
    applyStimulus(d, dc, 1'b1);
    repeat (100) @(negedge clk_in);
    checkEq("hold_scl", 32'(lcd_scl), 32'd0);
    checkEq("hold_sdi", 32'(lcd_sdi), 32'(expBits[0]));
    checkEq("hold_busy", 32'(busy), 32'd1);
    checkEq("hold_cs_n", 32'(lcd_cs_n), 32'd0);
    checkEq("hold_no_progress", 32'(obsBits.size() - obsBase), 32'd0);
    sckRun = 1'b1;
    waitIdle("hold");
    checkOutput("hold");

    $display("[TB] random bytes with random tick rates");
    for (int k = 0; k < 8; k++) begin
      halfPeriod = $urandom_range(1, 5);
      d    = 8'($urandom);
      dc   = 1'($urandom_range(0, 1));
      last = (k == 7) ? 1'b1 : 1'($urandom_range(0, 1));
      applyStimulus(d, dc, last);
      waitIdle($sformatf("rnd%0d", k));
      checkOutput($sformatf("rnd%0d", k));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
